// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Covers operand widths, funct3 opcodes and FSM states.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock on a shared 64-bit accumulator.
// Multiply uses shift-add; divide uses restoring division on magnitudes, with signs fixed up at the end.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [RA_W-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RA_W-1:0] rd_out,
    output logic            wb_en
);

    state_t              r_state;
    state_t              w_stateNext;
    logic [2:0]          r_op;
    logic [RA_W-1:0]     r_rd;
    logic                r_signA;
    logic                r_signB;
    logic                r_fast;
    logic [4:0]          r_count;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_accum;
    logic [XLEN-1:0]     r_result;

    logic                w_isDiv;
    logic                w_negA;
    logic                w_negB;
    logic [XLEN-1:0]     w_absA;
    logic [XLEN-1:0]     w_absB;
    logic                w_fast;
    logic [2*XLEN-1:0]   w_fastAccum;
    logic [XLEN:0]       w_mulSum;
    logic [XLEN:0]       w_divShift;
    logic [XLEN+1:0]     w_divDiff;
    logic                w_noBorrow;
    logic [2*XLEN-1:0]   w_iterAccum;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_signResult;

    // Operand capture: sign flags are pre-masked by opcode, so MULHSU never sees rs2 as negative.
    always_comb begin
        w_isDiv  = op[2];
        w_negA   = rs1_val[XLEN-1] &
                   ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
        w_negB   = rs2_val[XLEN-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        w_absA   = w_negA ? (~rs1_val + 1'b1) : rs1_val;
        w_absB   = w_negB ? (~rs2_val + 1'b1) : rs2_val;
        w_fast   = 1'b0;
        w_fastAccum = '0;
        if (w_isDiv && (rs2_val == '0)) begin
            w_fast      = 1'b1;
            w_fastAccum = {rs1_val, {XLEN{1'b1}}};
        end else if (((op == OP_DIV) || (op == OP_REM)) &&
                     (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF)) begin
            w_fast      = 1'b1;
            w_fastAccum = {32'h0000_0000, 32'h8000_0000};
        end
    end

    // One iteration step; accumulator is {partial product : multiplier} or {remainder : quotient}.
    always_comb begin
        w_mulSum    = {1'b0, r_accum[2*XLEN-1:XLEN]} + (r_accum[0] ? {1'b0, r_opnd} : '0);
        w_divShift  = {r_accum[2*XLEN-1:XLEN], r_accum[XLEN-1]};
        w_divDiff   = {1'b0, w_divShift} - {2'b00, r_opnd};
        w_noBorrow  = ~w_divDiff[XLEN+1];
        if (r_op[2]) begin
            w_iterAccum = {(w_noBorrow ? w_divDiff[XLEN-1:0] : w_divShift[XLEN-1:0]),
                           r_accum[XLEN-2:0], w_noBorrow};
        end else begin
            w_iterAccum = {w_mulSum, r_accum[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod = (r_signA ^ r_signB) ? (~r_accum + 1'b1) : r_accum;
        w_quot = (!r_fast && (r_signA ^ r_signB)) ? (~r_accum[XLEN-1:0] + 1'b1) : r_accum[XLEN-1:0];
        w_rem  = (!r_fast && r_signA) ? (~r_accum[2*XLEN-1:XLEN] + 1'b1) : r_accum[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                       w_signResult = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_signResult = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_signResult = w_quot;
            default:                      w_signResult = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Fast-path ops skip CALC but still pass through SIGN, which lands done one cycle after start.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start) w_stateNext = w_fast ? SIGN : CALC;
            CALC:    if (r_count == 5'd31) w_stateNext = SIGN;
            SIGN:    w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_signA  <= 1'b0;
            r_signB  <= 1'b0;
            r_fast   <= 1'b0;
            r_count  <= '0;
            r_opnd   <= '0;
            r_accum  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_rd    <= rd_in;
                        r_signA <= w_negA;
                        r_signB <= w_negB;
                        r_fast  <= w_fast;
                        r_count <= '0;
                        r_opnd  <= w_isDiv ? w_absB : w_absA;
                        r_accum <= w_fast ? w_fastAccum
                                          : {{XLEN{1'b0}}, (w_isDiv ? w_absA : w_absB)};
                    end
                end
                CALC: begin
                    r_accum <= w_iterAccum;
                    r_count <= r_count + 5'd1;
                end
                SIGN:    r_result <= w_signResult;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy   = (r_state != IDLE);
        done   = (r_state == DONE);
        result = r_result;
        rd_out = r_rd;
        wb_en  = done & (r_rd != '0);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops,
// compared against an arithmetic reference model of RV32M semantics.
module tb_muldiv_unit;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;
    logic [4:0]  rdIn;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;
    logic        wbEn;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cycleCnt   = 0;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs1_val (rs1Val),
        .rs2_val (rs2Val),
        .rd_in   (rdIn),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rdOut),
        .wb_en   (wbEn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // RV32M results straight from signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (o)
            MUL:    begin p = ua * ub; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0)) return 1;
        if (((o == DIV) || (o == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launches one op, scrambles the inputs right after capture, and checks the whole response.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input string tag);
        logic [31:0] expRes;
        int          nStart;
        int          lat;
        expRes = refModel(o, a, b);
        @(negedge clk);
        op = o; rs1Val = a; rs2Val = b; rdIn = rd; start = 1'b1;
        @(posedge clk);
        #1;
        nStart = cycleCnt;
        start  = 1'b0;
        op     = 3'($urandom);
        rs1Val = $urandom;
        rs2Val = $urandom;
        rdIn   = 5'($urandom);
        @(negedge clk);
        checkOutput({tag, "_busy"}, {63'h0, busy}, 64'h1);
        while ((done !== 1'b1) && ((cycleCnt - nStart) < 40)) @(negedge clk);
        lat = cycleCnt - nStart;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(expLatency(o, a, b)));
        checkOutput({tag, "_result"}, {32'h0, result}, {32'h0, expRes});
        checkOutput({tag, "_rd"}, {59'h0, rdOut}, {59'h0, rd});
        checkOutput({tag, "_wb_en"}, {63'h0, wbEn}, {63'h0, (rd != 5'd0)});
        @(negedge clk);
        checkOutput({tag, "_done_drop"}, {62'h0, done, busy}, 64'h0);
    endtask

    initial begin
        int          nStart;
        int          doneSeen;
        int          firstLat;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;

        reset = 1'b0; start = 1'b0; op = '0; rs1Val = '0; rs2Val = '0; rdIn = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {busy, done, wbEn, rdOut, result}, 64'h0);
        reset = 1'b1;

        applyStimulus(MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  "mul_7xm3");
        applyStimulus(MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  "mulh_min");
        applyStimulus(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  "mulhu_max");
        applyStimulus(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  "mulhsu_max");
        applyStimulus(DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  "div_m7_2");
        applyStimulus(REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  "rem_m7_2");
        applyStimulus(DIVU,   32'hFFFF_FFFF,  32'd2,         5'd7,  "divu_max_2");
        applyStimulus(DIV,    32'd5,          32'd0,         5'd8,  "div_by0");
        applyStimulus(REMU,   32'd5,          32'd0,         5'd9,  "remu_by0");
        applyStimulus(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, "div_ovf");
        applyStimulus(REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, "rem_ovf");
        applyStimulus(REMU,   32'd100,        32'd7,         5'd0,  "remu_rd0");
        applyStimulus(MUL,    32'd0,          32'd0,         5'd1,  "mul_zero");
        applyStimulus(REM,    32'd7,          32'd0,         5'd12, "rem_by0");
        applyStimulus(DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd13, "divu_big");

        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3:       a = {1'b1, 31'($urandom_range(0, 255))};
                default: ;
            endcase
            applyStimulus(o, a, b, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
        end

        // A second start during CALC must neither capture nor produce another done.
        @(negedge clk);
        op = MUL; rs1Val = 32'd1000; rs2Val = 32'd77; rdIn = 5'd12; start = 1'b1;
        @(posedge clk);
        #1;
        nStart = cycleCnt;
        start  = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = DIVU; rs1Val = 32'd5; rs2Val = 32'd0; rdIn = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        doneSeen = 0;
        firstLat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneSeen++;
                if (firstLat == 0) firstLat = cycleCnt - nStart;
                checkOutput("busy_start_result", {32'h0, result}, 64'd77000);
                checkOutput("busy_start_rd", {59'h0, rdOut}, 64'd12);
            end
        end
        checkOutput("busy_start_done_count", 64'(doneSeen), 64'd1);
        checkOutput("busy_start_latency", 64'(firstLat), 64'd33);

        // Reset in the middle of CALC clears everything immediately.
        @(negedge clk);
        op = MUL; rs1Val = 32'h1234; rs2Val = 32'h5678; rdIn = 5'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_outputs", {busy, done, wbEn, rdOut, result}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk) begin
            if (done === 1'b1) checkOutput("midreset_no_done", {63'h0, done}, 64'h0);
        end
        applyStimulus(MUL, 32'd3, 32'd4, 5'd9, "mul_after_reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
